// File: rtl/mul_lopd_norm_pipe.sv
// ---------------------------------------------------------------------------
// mul_lopd_norm_pipe
//
// Pipelined leading-one detector and normaliser for the FPU multiplier
// mantissa product. For every input beat it produces the leading-zero count,
// an all-zero flag and the mantissa shifted so that its leading one lands on
// the MSB. A sideband tag (unadjusted exponent/sign) travels with the beat.
//
// Pipeline:
//   [S0]  optional input register (MUL_LOPD_IN_REG_EN defined)
//   S1    per-chunk zero flag + local leading-zero count, data/tag registered
//   S2    first non-zero chunk select, count assembly, barrel shift, outputs
//
// Optional feature macro: MUL_LOPD_IN_REG_EN
//   Defined   -> extra input register stage, latency 3 cycles.
//   Undefined -> S1 samples the ports directly, latency 2 cycles.
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready    input beat handshake
//   i_data, i_tag        mantissa to analyse, sideband
//   o_valid / i_ready    output beat handshake
//   o_lzc                zeros above the leading one (all ones for zero input)
//   o_zero_flag          input was all zeros
//   o_norm               i_data << o_lzc (zero for zero input)
//   o_tag                i_tag of the same beat
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. Each stage owns a valid bit and loads when it is
// empty or when its own contents leave on this edge, so ready never depends
// on the incoming valid. A producer holds valid and data stable until the
// beat is taken; the output side holds all of o_* stable while o_valid is
// high and i_ready is low.
// ---------------------------------------------------------------------------
module mul_lopd_norm_pipe #(
  parameter int SIZE_DATA  = 24,
  parameter int SIZE_LOPD  = 5,
  parameter int SIZE_CHUNK = 8,
  parameter int SIZE_TAG   = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data,
  input  logic [SIZE_TAG-1:0]  i_tag,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_LOPD-1:0] o_lzc,
  output logic                 o_zero_flag,
  output logic [SIZE_DATA-1:0] o_norm,
  output logic [SIZE_TAG-1:0]  o_tag
);

  localparam int N  = SIZE_DATA / SIZE_CHUNK;
  localparam int CW = (SIZE_CHUNK > 1) ? $clog2(SIZE_CHUNK) : 1;

  // Elaboration-time parameter sanity checks.
  if (SIZE_LOPD != $clog2(SIZE_DATA)) begin : g_bad_lopd
    $error("SIZE_LOPD must equal clog2(SIZE_DATA)");
  end
  if ((SIZE_DATA % SIZE_CHUNK) != 0 || SIZE_DATA < 8) begin : g_bad_data
    $error("SIZE_DATA must be a multiple of SIZE_CHUNK and at least 8");
  end
  if ((SIZE_CHUNK & (SIZE_CHUNK - 1)) != 0 || SIZE_CHUNK > SIZE_DATA) begin : g_bad_chunk
    $error("SIZE_CHUNK must be a power of two no larger than SIZE_DATA");
  end

  // Stage-to-stage handshake signals.
  logic                 s1_load;
  logic                 s2_load;
  logic                 in_valid;
  logic [SIZE_DATA-1:0] in_data;
  logic [SIZE_TAG-1:0]  in_tag;

  assign s2_load = !o_valid || i_ready;

`ifdef MUL_LOPD_IN_REG_EN
  // Stage 0: plain input register, same load rule as the other stages.
  logic                 s0_valid;
  logic                 s0_load;
  logic [SIZE_DATA-1:0] s0_data;
  logic [SIZE_TAG-1:0]  s0_tag;

  assign s0_load = !s0_valid || s1_load;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
      s0_tag   <= '0;
    end else if (s0_load) begin
      s0_valid <= i_valid;
      if (i_valid) begin
        s0_data <= i_data;
        s0_tag  <= i_tag;
      end
    end
  end

  assign in_valid = s0_valid;
  assign in_data  = s0_data;
  assign in_tag   = s0_tag;
  assign o_ready  = s0_load;
`else
  assign in_valid = i_valid;
  assign in_data  = i_data;
  assign in_tag   = i_tag;
  assign o_ready  = s1_load;
`endif

  // -------------------------------------------------------------------------
  // Stage 1: chunk-local analysis only. Chunk 0 is the most significant.
  // -------------------------------------------------------------------------
  logic [N-1:0]         c_zero;
  logic [N-1:0][CW-1:0] c_llzc;

  always_comb begin
    c_zero = '0;
    c_llzc = '0;
    for (int c = 0; c < N; c++) begin
      c_zero[c] = ~|in_data[SIZE_DATA-1-c*SIZE_CHUNK -: SIZE_CHUNK];
      // Scan from the chunk LSB upwards so the last hit is the highest one.
      for (int b = SIZE_CHUNK - 1; b >= 0; b--) begin
        if (in_data[SIZE_DATA-1-c*SIZE_CHUNK-b]) begin
          c_llzc[c] = CW'(b);
        end
      end
    end
  end

  logic                 s1_valid;
  logic [N-1:0]         s1_zero;
  logic [N-1:0][CW-1:0] s1_llzc;
  logic [SIZE_DATA-1:0] s1_data;
  logic [SIZE_TAG-1:0]  s1_tag;

  assign s1_load = !s1_valid || s2_load;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_zero  <= '0;
      s1_llzc  <= '0;
      s1_data  <= '0;
      s1_tag   <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_zero <= c_zero;
        s1_llzc <= c_llzc;
        s1_data <= in_data;
        s1_tag  <= in_tag;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: priority select of the first non-zero chunk, then barrel shift.
  // -------------------------------------------------------------------------
  logic [SIZE_LOPD-1:0] c_lzc;
  logic                 c_all_zero;
  logic [SIZE_DATA-1:0] c_norm;

  always_comb begin
    c_all_zero = &s1_zero;
    // All ones is the count reported for an all-zero mantissa.
    c_lzc      = '1;
    // Walk from the least significant chunk so the most significant
    // non-zero chunk is the final assignment.
    for (int k = N - 1; k >= 0; k--) begin
      if (!s1_zero[k]) begin
        c_lzc = SIZE_LOPD'(k * SIZE_CHUNK) + SIZE_LOPD'(s1_llzc[k]);
      end
    end
    c_norm = c_all_zero ? '0 : (s1_data << c_lzc);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      o_lzc       <= '0;
      o_zero_flag <= 1'b0;
      o_norm      <= '0;
      o_tag       <= '0;
    end else if (s2_load) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_lzc       <= c_lzc;
        o_zero_flag <= c_all_zero;
        o_norm      <= c_norm;
        o_tag       <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_mul_lopd_norm_pipe.sv
// ---------------------------------------------------------------------------
// tb_mul_lopd_norm_pipe
//
// Directed bench for mul_lopd_norm_pipe at default parameters (24-bit data,
// 8-bit chunks, 9-bit tag). Expected results come from a hand-computed
// vector table; a scoreboard queue holds the expected output beats in order.
// ---------------------------------------------------------------------------
module tb_mul_lopd_norm_pipe;

  localparam int SD = 24;
  localparam int SL = 5;
  localparam int SC = 8;
  localparam int ST = 9;
  localparam int EW = SL + 1 + SD + ST;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [SD-1:0] i_data = '0;
  logic [ST-1:0] i_tag = '0;
  logic          o_ready;
  logic          o_valid;
  logic [SL-1:0] o_lzc;
  logic          o_zero_flag;
  logic [SD-1:0] o_norm;
  logic [ST-1:0] o_tag;

  always #5 clk = ~clk;

  mul_lopd_norm_pipe #(
    .SIZE_DATA (SD),
    .SIZE_LOPD (SL),
    .SIZE_CHUNK(SC),
    .SIZE_TAG  (ST)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .i_tag      (i_tag),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_lzc      (o_lzc),
    .o_zero_flag(o_zero_flag),
    .o_norm     (o_norm),
    .o_tag      (o_tag)
  );

  // ---------------- vectors ----------------
  typedef struct {
    logic [SD-1:0] data;
    logic [ST-1:0] tag;
    logic [SL-1:0] lzc;
    logic          zero;
    logic [SD-1:0] norm;
  } vec_t;

  vec_t vecs[13];

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  bit rand_ready = 1'b0;

  function automatic vec_t mk(input logic [SD-1:0] d, input logic [ST-1:0] t,
                              input logic [SL-1:0] l, input logic z,
                              input logic [SD-1:0] n);
    vec_t v;
    v.data = d; v.tag = t; v.lzc = l; v.zero = z; v.norm = n;
    return v;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s (t=%0t)", name, what, $time);
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; optionally randomise i_ready.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) i_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one beat and keep it until it is taken; i_valid stays high on
  // return so the caller either sends again or drops it.
  task automatic send(input vec_t v);
    int waited;
    waited  = 0;
    i_valid = 1'b1;
    i_data  = v.data;
    i_tag   = v.tag;
    @(negedge clk);
    while (!o_ready && waited < 50) begin
      tick();
      @(negedge clk);
      waited++;
    end
    if (!o_ready) fail_event("send_timeout", "o_ready stuck low, expected beat accepted");
    else exp_q.push_back({v.lzc, v.zero, v.norm, v.tag});
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) fail_event("drain_timeout", "beats still outstanding, expected none");
  endtask

  // ---------------- scoreboard ----------------
  // Every output beat must match the head of the queue; while stalled the
  // outputs must keep showing that same head beat.
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (exp_q.size() == 0) begin
        fail_event("unexpected_beat", "o_valid with empty queue, expected no beat");
      end else begin
        check(i_ready ? "out_beat" : "hold_beat",
              64'({o_lzc, o_zero_flag, o_norm, o_tag}), 64'(exp_q[0]));
        if (i_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    vecs[0]  = mk(24'h800000, 9'h001, 5'd0,  1'b0, 24'h800000);
    vecs[1]  = mk(24'h000001, 9'h002, 5'd23, 1'b0, 24'h800000);
    vecs[2]  = mk(24'h00ABCD, 9'h003, 5'd8,  1'b0, 24'hABCD00);
    vecs[3]  = mk(24'h000000, 9'h1A5, 5'd31, 1'b1, 24'h000000);
    vecs[4]  = mk(24'h010000, 9'h0F0, 5'd7,  1'b0, 24'h800000);
    vecs[5]  = mk(24'h008000, 9'h00F, 5'd8,  1'b0, 24'h800000);
    vecs[6]  = mk(24'h000100, 9'h155, 5'd15, 1'b0, 24'h800000);
    vecs[7]  = mk(24'h000080, 9'h0AA, 5'd16, 1'b0, 24'h800000);
    vecs[8]  = mk(24'hFFFFFF, 9'h1FF, 5'd0,  1'b0, 24'hFFFFFF);
    vecs[9]  = mk(24'h123456, 9'h012, 5'd3,  1'b0, 24'h91A2B0);
    vecs[10] = mk(24'h0000F0, 9'h100, 5'd16, 1'b0, 24'hF00000);
    vecs[11] = mk(24'h07FFFF, 9'h07F, 5'd5,  1'b0, 24'hFFFFE0);
    vecs[12] = mk(24'h000003, 9'h033, 5'd22, 1'b0, 24'hC00000);

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_lzc",   64'(o_lzc),   64'd0);
    check("rst_o_zero",  64'(o_zero_flag), 64'd0);
    check("rst_o_norm",  64'(o_norm),  64'd0);
    check("rst_o_tag",   64'(o_tag),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("rst_ready", 64'(o_ready), 64'd1);

    // Basic counts and 2-cycle latency, back-to-back beats.
    tick();
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_data = vecs[0].data; i_tag = vecs[0].tag;
    exp_q.push_back({vecs[0].lzc, vecs[0].zero, vecs[0].norm, vecs[0].tag});
    tick();
    i_data = vecs[1].data; i_tag = vecs[1].tag;
    exp_q.push_back({vecs[1].lzc, vecs[1].zero, vecs[1].norm, vecs[1].tag});
    @(negedge clk);
    check("lat_edge_n", 64'(o_valid), 64'd0);
    tick();
    i_data = vecs[2].data; i_tag = vecs[2].tag;
    exp_q.push_back({vecs[2].lzc, vecs[2].zero, vecs[2].norm, vecs[2].tag});
    @(negedge clk);
    check("lat_edge_n1", 64'(o_valid), 64'd1);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    check("lat_edge_n2", 64'(o_valid), 64'd1);
    tick();
    @(negedge clk);
    check("lat_edge_n3", 64'(o_valid), 64'd1);
    tick();
    @(negedge clk);
    check("lat_edge_n4", 64'(o_valid), 64'd0);
    check("lat_queue_empty", 64'(exp_q.size()), 64'd0);

    // Whole table with random gaps and random downstream stalls.
    tick();
    rand_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        i_valid = 1'b0;
        repeat (gap) tick();
      end
      send(vecs[i]);
    end
    i_valid = 1'b0;
    rand_ready = 1'b0;
    i_ready = 1'b1;
    drain();

    // Backpressure: two beats fill the pipe, a third waits at the input.
    tick();
    i_ready = 1'b0;
    send(vecs[3]);
    send(vecs[2]);
    i_data = vecs[4].data; i_tag = vecs[4].tag;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(o_ready), 64'd0);
      check("bp_valid_held", 64'(o_valid), 64'd1);
      tick();
    end
    i_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_back", 64'(o_ready), 64'd1);
    exp_q.push_back({vecs[4].lzc, vecs[4].zero, vecs[4].norm, vecs[4].tag});
    tick();
    i_valid = 1'b0;
    drain();
    tick();
    @(negedge clk);
    check("bp_no_extra", 64'(o_valid), 64'd0);

    // Reset mid-stream with two beats in flight.
    tick();
    i_ready = 1'b0;
    send(vecs[2]);
    send(vecs[9]);
    i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_o_valid", 64'(o_valid), 64'd0);
    check("mrst_o_lzc",   64'(o_lzc),   64'd0);
    check("mrst_o_zero",  64'(o_zero_flag), 64'd0);
    check("mrst_o_norm",  64'(o_norm),  64'd0);
    check("mrst_o_tag",   64'(o_tag),   64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    i_ready = 1'b1;
    @(negedge clk);
    check("mrst_ready", 64'(o_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mrst_no_stale", 64'(o_valid), 64'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_lopd_norm_pipe.md
# mul_lopd_norm_pipe

Pipelined, parametrised leading-one detector and normaliser for the FPU multiplier datapath. It accepts a raw mantissa product slice of `SIZE_DATA` bits and returns three results: the leading-zero count, an all-zero flag, and the mantissa left-shifted so its leading one sits at the MSB. A sideband tag, typically the unadjusted exponent and sign, travels alongside so the exponent-adjust stage stays aligned. It generalises the fixed 24-bit combinational detector to any width and adds a valid/ready pipeline with backpressure.

## Interface
- `SIZE_DATA`, default 24: input/output mantissa width; must be a multiple of `SIZE_CHUNK`, ≥ 8.
- `SIZE_LOPD`, default 5: count width; must equal `$clog2(SIZE_DATA)` (elaboration-time check).
- `SIZE_CHUNK`, default 8: stage-1 segment width; power of two, ≤ `SIZE_DATA`.
- `SIZE_TAG`, default 9: sideband width, passed through untouched.

- `i_clk`, input, 1: clock, rising edge.
- `i_rst_n`, input, 1: reset, asynchronous assert, active-low.
- `i_valid`, input, 1: input beat valid.
- `o_ready`, output, 1: block can accept an input beat this cycle.
- `i_data`, input, `SIZE_DATA`: mantissa to analyse.
- `i_tag`, input, `SIZE_TAG`: sideband.
- `o_valid`, output, 1: output beat valid.
- `i_ready`, input, 1: downstream accepts the output beat.
- `o_lzc`, output, `SIZE_LOPD`: number of zeros above the leading one, counted from the MSB.
- `o_zero_flag`, output, 1: input was all zeros.
- `o_norm`, output, `SIZE_DATA`: `i_data << o_lzc`.
- `o_tag`, output, `SIZE_TAG`: `i_tag` of the same beat.

## Operation
- **Stage 1 (S1):** split `i_data` into `N = SIZE_DATA/SIZE_CHUNK` chunks, with chunk 0 at the MSB. For each chunk, register:
  - the chunk's zero flag;
  - its local leading-zero count (`$clog2(SIZE_CHUNK)` bits);
  - the data and tag.
- **Stage 2 (S2):**
  - Select the first non-zero chunk `k` from the MSB.
  - `lzc = k*SIZE_CHUNK + local_lzc[k]`.
  - `norm = data << lzc`, with zeros filled in at the LSB.
  - Register all S2 outputs.
- **All-zero input:**
  - `o_zero_flag = 1`.
  - `o_lzc` = all ones (e.g. 5'b11111 for 24 bits, not 24).
  - `o_norm = 0`.
- **Handshake per stage:** each stage holds a valid bit.
  - A stage loads when it is empty or its downstream consumes this cycle.
  - `o_ready = !s1_valid || s2_load`.
  - `s2_load = !o_valid || i_ready`.
  - This is a full-throughput pipeline with no bubbles under continuous `i_ready`.
- **Hold under backpressure:** while `o_valid && !i_ready`, all outputs are held stable. Data, tag and flags never change while valid is high and unaccepted.
- **Input side:** the producer must not drop `i_valid` or change data while `i_valid && !o_ready`. The block does not check this.
- **Dropped beats:** none under any `i_valid`/`i_ready` pattern. Order is preserved.
- **Reset (asynchronous, any time including mid-stream):**
  - All valid bits clear immediately.
  - `o_valid=0`, `o_lzc=0`, `o_zero_flag=0`, `o_norm=0`, `o_tag=0`.
  - `o_ready` is 1 in the first cycle after deassertion.
  - In-flight beats are discarded.

## Timing
- Latency is 2 cycles from an accepted input (`i_valid && o_ready` at edge n) to `o_valid` high after edge n+1.
- Throughput is 1 beat/cycle.
- With `MUL_LOPD_IN_REG_EN` set, latency becomes 3 cycles; throughput is unchanged.
- `o_ready` depends combinationally on `i_ready` and internal state only, never on `i_valid`.
- When output is full and input is arriving in the same cycle that `i_ready` is asserted, both transfers occur in that cycle.
- The critical path is the S2 chunk priority select plus a barrel shift over `SIZE_DATA`. S1 contains only chunk-local logic.

## Configuration
- `MUL_LOPD_IN_REG_EN`, when defined:
  - Adds a stage 0 that only registers `i_data`/`i_tag`, with the same valid/ready rule.
  - Latency is 3 cycles.
  - `o_ready` is computed from the stage-0 state.
- When undefined, S1 samples the ports directly and latency is 2 cycles.
- Functional results are identical either way.

## Test plan
- **Basic counts:** with `SIZE_DATA=24` and `i_ready=1`, feed `0x800000`, `0x000001`, `0x00ABCD` back-to-back:
  - lzc = 0, 23, 8;
  - norm = `0x800000`, `0x800000`, `0xABCD00`;
  - `o_valid` on 3 consecutive cycles starting 2 cycles after the first accept.
- **All-zero input:** `i_data=0x000000`, `i_tag=0x1A5` → `o_zero_flag=1`, `o_lzc=5'b11111`, `o_norm=0`, `o_tag=0x1A5`.
- **Backpressure:** hold `i_ready=0` for 5 cycles with continuous input.
  - After 2 accepted beats, `o_ready` falls and the outputs stay constant.
  - Releasing `i_ready` drains all beats in order with none lost.
- **Chunk boundaries:** inputs `1<<16`, `1<<15`, `1<<8`, `1<<7` → lzc = 7, 8, 15, 16.
- **Reset mid-stream:** assert `i_rst_n=0` with 2 beats in flight.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, `o_ready=1` and no stale beat appears.
- **Parameter sweep:** `SIZE_DATA=32`, `SIZE_LOPD=5`, `SIZE_CHUNK=8`, 10k random inputs with random `i_valid`/`i_ready` compared against a reference model, both with and without `MUL_LOPD_IN_REG_EN`.
